// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
// Holds the FSM state encoding, SRAM bus widths and the word-index helper.
package mem_pkg;

    localparam int unsigned SRAM_AW    = 18;
    localparam int unsigned SRAM_DW    = 16;
    localparam int unsigned WORD_IDX_W = SRAM_AW - 1;
    localparam int unsigned CNT_W      = 4;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StDone
    } mem_state_e;

    // Out-of-range addresses simply wrap onto the truncated index.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] address,
                                                         input logic [31:0] base);
        logic [31:0] offset;
        offset = address - base;
        return offset[WORD_IDX_W+1:2];
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: restarts from zero on start, flags the final cycle of a phase.
module sram_wait_counter
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = start ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == limit - 1'b1);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: splits one 32-bit load/store into two 16-bit SRAM accesses,
// holding ready low as the pipeline freeze while the access is in flight.
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [CNT_W-1:0] WaitLimit = CNT_W'(WAIT_CYCLES);

    mem_state_e              state_q, state_d;
    logic [WORD_IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    is_store_q, is_store_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    req;
    logic                    cnt_start;
    logic                    phase_last;

    // Gated by reset so ready reads high while reset is held, even with a request present.
    assign req = rst & (rd_en | wr_en);

    sram_wait_counter u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .start (cnt_start),
        .limit (WaitLimit),
        .last  (phase_last)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        is_store_d  = is_store_q;
        rd_data_d   = rd_data_q;
        cnt_start   = 1'b0;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        unique case (state_q)
            StIdle: begin
                ready = ~req;
                if (req) begin
                    state_d    = StLo;
                    idx_d      = word_index(address, BASE_ADDR);
                    wdata_d    = wr_data;
                    is_store_d = wr_en;  // store wins when both are requested
                    cnt_start  = 1'b1;
                end
            end
            StLo: begin
                sram_addr = {idx_q, 1'b0};
                if (is_store_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                end
                if (phase_last) begin
                    if (!is_store_q) begin
                        rd_data_d[15:0] = sram_dq_in;
                    end
                    state_d   = StHi;
                    cnt_start = 1'b1;
                end
            end
            StHi: begin
                sram_addr = {idx_q, 1'b1};
                if (is_store_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                end
                if (phase_last) begin
                    if (!is_store_q) begin
                        rd_data_d[31:16] = sram_dq_in;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                // Requests seen here are deliberately not sampled until the next IDLE cycle.
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_store_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_store_q <= is_store_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: vector table plus random accesses against a word-level
// SRAM reference, with hand sequences for reset mid-access and the single-cycle wait case.
module tb_mem_stage_sram_ctrl;

    localparam int unsigned W     = 2;
    localparam int unsigned W1    = 1;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          NV    = 26;
    localparam int          MSIZE = 262144;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        rd_en, wr_en, ready, sram_dq_oe, sram_we_n;
    logic [31:0] address, wr_data, rd_data;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        rd_en1, wr_en1, ready1, sram_dq_oe1, sram_we_n1;
    logic [31:0] address1, wr_data1, rd_data1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;

    int total = 0;
    int bad   = 0;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W1), .BASE_ADDR(BASE)) u_dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
        .wr_data(wr_data1), .rd_data(rd_data1), .ready(ready1), .sram_addr(sram_addr1),
        .sram_dq_out(sram_dq_out1), .sram_dq_in(sram_dq_in1), .sram_dq_oe(sram_dq_oe1),
        .sram_we_n(sram_we_n1)
    );

    function automatic logic [15:0] init_val(input logic [17:0] a);
        if (a == 18'd4) return 16'h1234;
        if (a == 18'd5) return 16'h5678;
        return a[15:0] ^ 16'hA55A ^ {a[17:16], 14'd0};
    endfunction

    function automatic logic [15:0] pat1(input logic [17:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    // SRAM device model seen by the W=2 instance.
    logic [15:0] sram_mem [0:MSIZE-1];
    bit          sram_vld [0:MSIZE-1];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr] <= sram_dq_out;
            sram_vld[sram_addr] <= 1'b1;
        end
    end
    assign sram_dq_in  = sram_vld[sram_addr] ? sram_mem[sram_addr] : init_val(sram_addr);
    assign sram_dq_in1 = pat1(sram_addr1);

    // Word-level reference contents and expected load register.
    logic [15:0] ref_mem [0:MSIZE-1];
    bit          ref_vld [0:MSIZE-1];
    logic [31:0] ref_rd = 32'h0;

    function automatic logic [15:0] ref_half(input logic [17:0] a);
        return ref_vld[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic model_access(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] exp_rd);
        logic [31:0] word;
        logic [17:0] lo_a, hi_a;
        word = (addr - BASE) >> 2;
        lo_a = {word[16:0], 1'b0};
        hi_a = {word[16:0], 1'b1};
        if (wr) begin
            ref_mem[lo_a] = wdata[15:0];
            ref_vld[lo_a] = 1'b1;
            ref_mem[hi_a] = wdata[31:16];
            ref_vld[hi_a] = 1'b1;
        end else if (rd) begin
            ref_rd = {ref_half(hi_a), ref_half(lo_a)};
        end
        exp_rd = ref_rd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rd_en   = v.rd;
        wr_en   = v.wr;
        address = v.addr;
        wr_data = v.wdata;
    endtask

    task automatic drive_idle();
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        address = 32'h0;
        wr_data = 32'h0;
    endtask

    // Entered at the start of cycle 0 with v already driven; leaves at the start of the
    // cycle after DONE, with nxt (or idle) driven since the DONE cycle.
    task automatic run_vec(input int tag, input vec_t v, input bit has_next, input vec_t nxt);
        logic [31:0] word;
        logic [16:0] idx;
        bit          in_lo, in_hi;
        word = (v.addr - BASE) >> 2;
        idx  = word[16:0];
        for (int k = 0; k <= 2 * W + 1; k++) begin
            if (k >= 1 && k <= 2 * W) begin
                rd_en   = 1'($urandom);
                wr_en   = 1'($urandom);
                address = $urandom;
                wr_data = $urandom;
            end
            if (k == 2 * W + 1) begin
                if (has_next) drive(nxt);
                else drive_idle();
            end
            @(negedge clk);
            in_lo = (k >= 1) && (k <= W);
            in_hi = (k > W) && (k <= 2 * W);
            chk($sformatf("v%0d k%0d ready", tag, k), 32'(ready), 32'(k == 2 * W + 1));
            chk($sformatf("v%0d k%0d we_n", tag, k), 32'(sram_we_n),
                32'(!((in_lo || in_hi) && v.wr)));
            chk($sformatf("v%0d k%0d oe", tag, k), 32'(sram_dq_oe),
                32'((in_lo || in_hi) && v.wr));
            if (in_lo || in_hi) begin
                chk($sformatf("v%0d k%0d addr", tag, k), 32'(sram_addr), 32'({idx, in_hi}));
                if (v.wr) begin
                    chk($sformatf("v%0d k%0d dq_out", tag, k), 32'(sram_dq_out),
                        32'(in_hi ? v.wdata[31:16] : v.wdata[15:0]));
                end
            end
            if (k == 2 * W + 1) begin
                chk($sformatf("v%0d rd_data", tag), rd_data, v.exp_rd);
            end
            @(posedge clk);
            #1;
        end
    endtask

    vec_t        vecs [NV];
    vec_t        hv;
    vec_t        none;
    logic [31:0] dummy;

    initial begin
        none = '{rd: 1'b0, wr: 1'b0, addr: 32'h0, wdata: 32'h0, exp_rd: 32'h0};
        rst = 1'b1;
        rd_en = 1'b1; wr_en = 1'b1; address = 32'h0; wr_data = 32'h0;
        rd_en1 = 1'b0; wr_en1 = 1'b0; address1 = 32'h0; wr_data1 = 32'h0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'h1);
        chk("reset we_n", 32'(sram_we_n), 32'h1);
        chk("reset oe", 32'(sram_dq_oe), 32'h0);
        chk("reset addr", 32'(sram_addr), 32'h0);
        chk("reset dq_out", 32'(sram_dq_out), 32'h0);
        chk("reset rd_data", rd_data, 32'h0);
        drive_idle();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d ready", i), 32'(ready), 32'h1);
            chk($sformatf("idle%0d we_n", i), 32'(sram_we_n), 32'h1);
            chk($sformatf("idle%0d oe", i), 32'(sram_dq_oe), 32'h0);
        end

        vecs[0] = '{rd: 1'b0, wr: 1'b1, addr: 32'd1024, wdata: 32'hDEADBEEF, exp_rd: 32'h0};
        vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 32'd1032, wdata: 32'h0, exp_rd: 32'h56781234};
        vecs[2] = '{rd: 1'b0, wr: 1'b1, addr: 32'd2048, wdata: 32'hCAFEF00D,
                    exp_rd: 32'h56781234};
        vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'd2048, wdata: 32'h0, exp_rd: 32'hCAFEF00D};
        vecs[4] = '{rd: 1'b1, wr: 1'b1, addr: 32'd3000, wdata: 32'h11112222,
                    exp_rd: 32'hCAFEF00D};
        vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'd3000, wdata: 32'h0, exp_rd: 32'h11112222};
        for (int i = 0; i < 6; i++) begin
            model_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, dummy);
        end
        for (int i = 6; i < NV; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            vecs[i].rd    = (op != 1);
            vecs[i].wr    = (op != 0);
            vecs[i].wdata = $urandom;
            if ($urandom_range(0, 4) == 0) vecs[i].addr = $urandom;
            else vecs[i].addr = BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            model_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                         vecs[i].exp_rd);
        end

        @(posedge clk);
        #1 drive(vecs[0]);
        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i], i < NV - 1, (i < NV - 1) ? vecs[i + 1] : none);
        end

        // Reset during the high half of a store.
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b1; address = BASE + 32'd400; wr_data = 32'hA1B2C3D4;
        repeat (W + 1) @(posedge clk);
        #1 drive_idle();
        #1;
        chk("pre-rst we_n", 32'(sram_we_n), 32'h0);
        chk("pre-rst addr", 32'(sram_addr), 32'd201);
        chk("pre-rst dq_out", 32'(sram_dq_out), 32'hA1B2);
        rst = 1'b0;
        #1;
        chk("rst we_n", 32'(sram_we_n), 32'h1);
        chk("rst oe", 32'(sram_dq_oe), 32'h0);
        chk("rst ready", 32'(ready), 32'h1);
        chk("rst addr", 32'(sram_addr), 32'h0);
        chk("rst rd_data", rd_data, 32'h0);
        ref_mem[18'd200] = 16'hC3D4;
        ref_vld[18'd200] = 1'b1;
        ref_rd = 32'h0;
        @(posedge clk);
        #1;
        chk("rst hold ready", 32'(ready), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        hv = '{rd: 1'b1, wr: 1'b0, addr: 32'd1032, wdata: 32'h0, exp_rd: 32'h0};
        model_access(1'b1, 1'b0, hv.addr, hv.wdata, hv.exp_rd);
        drive(hv);
        run_vec(100, hv, 1'b0, none);

        // Single-cycle waits: 3-cycle stall, address change mid-access ignored.
        rd_en1 = 1'b1; address1 = BASE + 32'd28;
        @(negedge clk);
        chk("w1 c0 ready", 32'(ready1), 32'h0);
        @(posedge clk);
        #1 rd_en1 = 1'b0; address1 = 32'hFFFF0000;
        @(negedge clk);
        chk("w1 c1 ready", 32'(ready1), 32'h0);
        chk("w1 c1 addr", 32'(sram_addr1), 32'd14);
        chk("w1 c1 we_n", 32'(sram_we_n1), 32'h1);
        @(negedge clk);
        chk("w1 c2 ready", 32'(ready1), 32'h0);
        chk("w1 c2 addr", 32'(sram_addr1), 32'd15);
        @(negedge clk);
        chk("w1 c3 ready", 32'(ready1), 32'h1);
        chk("w1 c3 rd_data", rd_data1, {pat1(18'd15), pat1(18'd14)});
        @(negedge clk);
        chk("w1 c4 ready", 32'(ready1), 32'h1);
        chk("w1 c4 oe", 32'(sram_dq_oe1), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-stage controller between the EXE stage register and the off-chip 16-bit SRAM. It converts one 32-bit load or store from the EXE stage into two sequential 16-bit SRAM accesses, each lasting a fixed number of cycles. While an access is in progress it holds `ready` low, which the pipeline uses as its freeze. Load data is presented to the MEM/WB register.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: cycles per 16-bit SRAM access; legal range 1..15.
- `BASE_ADDR`, 32'd1024: byte address that maps to SRAM word 0.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-low reset.
- `rd_en` in 1: load request from the EXE stage register.
- `wr_en` in 1: store request from the EXE stage register.
- `address` in 32: byte address (ALU result).
- `wr_data` in 32: store value.
- `rd_data` out 32: load result.
- `ready` out 1: high when no access is pending; low means freeze the pipeline.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: write data driven to the SRAM.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_dq_oe` out 1: enables the top-level tristate onto the DQ bus.
- `sram_we_n` out 1: SRAM write enable, active-low.

## Operation
- Word index is `(address - BASE_ADDR) >> 2`, truncated to 17 bits. Bits [1:0] are ignored.
- Each word access uses two half-word addresses:
  - low half: `sram_addr = {idx, 1'b0}`
  - high half: `sram_addr = {idx, 1'b1}`
- FSM states are IDLE, LO, HI, DONE.
- IDLE:
  - `rd_en | wr_en` latches `address`, `wr_data` and the operation, then moves to LO.
  - `ready` is combinationally low in this same cycle, so the upstream stage freezes immediately.
- LO: lasts `WAIT_CYCLES` cycles, then moves to HI.
- HI: lasts `WAIT_CYCLES` cycles, then moves to DONE.
- DONE:
  - Lasts 1 cycle with `ready`=1; the pipeline advances on this edge.
  - Next state is IDLE.
- Phase counter: 4 bits. It loads 0 on entry to LO or HI and increments each cycle; the phase ends when the count equals `WAIT_CYCLES-1`.
- Stores:
  - `sram_we_n`=0 and `sram_dq_oe`=1 throughout LO and HI.
  - `sram_dq_out` is `wr_data[15:0]` in LO and `wr_data[31:16]` in HI.
- Loads:
  - `sram_we_n`=1 and `sram_dq_oe`=0.
  - `sram_dq_in` is captured on the last cycle of LO into `rd_data[15:0]`, and on the last cycle of HI into `rd_data[31:16]`.
- `rd_data` holds its value until the next load overwrites it. Stores do not change it.
- `rd_en` and `wr_en` both high: the store wins and the load is dropped.
- Address is outside the SRAM range: the access proceeds on the truncated index. There is no error flag.
- Inputs that change during LO, HI or DONE are ignored; the latched copies are used.

## Timing
- Reset values: state IDLE, counter 0, `rd_data`=0, `ready`=1, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.
- Reset asserted mid-access aborts immediately and returns all outputs to their reset values. A half-written word is acceptable.
- A request in cycle 0 holds `ready` low for cycles 0 through `2*WAIT_CYCLES`. `ready` is high in cycle `2*WAIT_CYCLES+1` (DONE), with the full `rd_data` valid.
- Stall cycles per access = `2*WAIT_CYCLES+1`.
- A request present in DONE is not re-sampled. It is sampled in the following IDLE cycle, so back-to-back requests are spaced `2*WAIT_CYCLES+2` cycles apart.
- With no request, `ready` stays high continuously and all SRAM outputs are idle (`we_n`=1, `oe`=0).

## Structure
- Shared package `mem_pkg` holds:
  - the state enum (IDLE, LO, HI, DONE);
  - `SRAM_AW`=18 and `SRAM_DW`=16;
  - the default `BASE_ADDR`.
- One sub-module, `sram_wait_counter`:
  - inputs: `clk`, `rst`, `start`, limit `WAIT_CYCLES`;
  - output: `last`.
- Bidirectional DQ tristating stays at the top level, not in this block.

## Test plan
- Store, `WAIT_CYCLES`=2, `address`=1024, `wr_data`=32'hDEADBEEF:
  - `sram_addr`=0 with `dq_out`=16'hBEEF for 2 cycles, then `sram_addr`=1 with `dq_out`=16'hDEAD for 2 cycles;
  - `we_n` low for 4 cycles; `ready` low for 5 cycles.
- Load from `address`=1032, SRAM model returning 16'h1234 at addr 4 and 16'h5678 at addr 5:
  - `sram_addr` sequence 4,4,5,5;
  - `rd_data`=32'h56781234 in the DONE cycle.
- Back-to-back store then load to the same address:
  - load returns the stored word;
  - second request starts exactly one IDLE cycle after DONE.
- `rd_en`=`wr_en`=1: a write occurs, `rd_data` is unchanged, and a single 5-cycle stall is seen.
- `rst` pulled low during HI of a store:
  - `we_n`=1, `oe`=0 and `ready`=1 asynchronously;
  - after release, a fresh load completes normally.
- `WAIT_CYCLES`=1: a load stalls exactly 3 cycles; `address` changing mid-access does not alter `sram_addr`.
